// File: rtl/led_mmio_scheduler.sv
// Memory-mapped LED scheduler: PATTERN/MODE/PERIOD registers, a prescaler
// and static/blink/chase display sequencing onto a 4-LED data word.
module led_mmio_scheduler #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter logic [31:0] DEFAULT_PERIOD = 32'd50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic [31:0] led_data,
    output logic        tick
);

    localparam logic [1:0] OFS_PATTERN = 2'd0;
    localparam logic [1:0] OFS_MODE    = 2'd1;
    localparam logic [1:0] OFS_PERIOD  = 2'd2;
    localparam logic [1:0] OFS_STATUS  = 2'd3;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_BLINK  = 2'd1;
    localparam logic [1:0] MODE_CHASE  = 2'd2;

    logic [3:0]  pattern_reg;
    logic [1:0]  mode_reg;
    logic [31:0] period_reg;
    logic [31:0] cnt_reg;
    logic        phase_reg;
    logic [3:0]  rot_reg;
    logic [31:0] led_data_reg;
    logic [31:0] rdata_reg;
    logic        rvalid_reg;
    logic        tick_reg;

    logic        hit;
    logic [1:0]  offset;
    logic        wr_pattern;
    logic        wr_mode;
    logic        wr_period;
    logic        cfg_write;
    logic        wrap;
    logic [31:0] period_next;
    logic [3:0]  rot_next;
    logic [3:0]  disp;
    logic [31:0] rd_mux;
    logic        addr_unused;

    // Word-aligned decode; byte lanes are not supported.
    assign addr_unused = ^addr[1:0];
    assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset      = addr[3:2];
    assign wr_pattern  = we && hit && (offset == OFS_PATTERN);
    assign wr_mode     = we && hit && (offset == OFS_MODE);
    assign wr_period   = we && hit && (offset == OFS_PERIOD);
    assign cfg_write   = wr_pattern || wr_mode || wr_period;
    assign wrap        = (cnt_reg == period_reg - 32'd1);
    assign period_next = (wdata == 32'd0) ? 32'd1 : wdata;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_next[gi] = rot_reg[(gi + 3) % 4];
        end
    endgenerate

    always_comb begin
        disp = 4'b0;
        case (mode_reg)
            MODE_STATIC: disp = pattern_reg;
            MODE_BLINK:  disp = phase_reg ? pattern_reg : 4'b0;
            MODE_CHASE:  disp = rot_reg;
            default:     disp = 4'b0;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (offset)
            OFS_PATTERN: rd_mux = {28'd0, pattern_reg};
            OFS_MODE:    rd_mux = {30'd0, mode_reg};
            OFS_PERIOD:  rd_mux = period_reg;
            OFS_STATUS:  rd_mux = {26'd0, phase_reg, (mode_reg != 2'd0), disp};
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pattern_reg  <= 4'd0;
            mode_reg     <= 2'd0;
            period_reg   <= DEFAULT_PERIOD;
            cnt_reg      <= 32'd0;
            phase_reg    <= 1'b1;
            rot_reg      <= 4'd0;
            led_data_reg <= 32'd0;
            rdata_reg    <= 32'd0;
            rvalid_reg   <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            if (wr_pattern) pattern_reg <= wdata[3:0];
            if (wr_mode)    mode_reg    <= wdata[1:0];
            if (wr_period)  period_reg  <= period_next;

            // A configuration store restarts the sequence from a known point.
            if (cfg_write || wrap) cnt_reg <= 32'd0;
            else                   cnt_reg <= cnt_reg + 32'd1;
            tick_reg <= wrap && !cfg_write;

            if (cfg_write)
                phase_reg <= 1'b1;
            else if (wrap && mode_reg == MODE_BLINK)
                phase_reg <= ~phase_reg;

            if (wr_pattern)
                rot_reg <= wdata[3:0];
            else if (wr_mode)
                rot_reg <= pattern_reg;
            else if (wrap && mode_reg == MODE_CHASE)
                rot_reg <= rot_next;

            led_data_reg <= {28'd0, disp};
            rvalid_reg   <= re && hit;
            if (re && hit) rdata_reg <= rd_mux;
        end
    end

    assign rdata    = rdata_reg;
    assign rvalid   = rvalid_reg;
    assign led_data = led_data_reg;
    assign tick     = tick_reg;

endmodule

// File: tb/tb_led_mmio_scheduler.sv
// Directed bench for led_mmio_scheduler: register access, prescaler ticks,
// blink/chase sequences, decode misses and mid-operation reset.
module tb_led_mmio_scheduler;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] led_data;
    logic        tick;

    int n_cmp = 0;
    int n_err = 0;

    led_mmio_scheduler #(
        .BASE_ADDR      (32'h0000_1000),
        .DEFAULT_PERIOD (32'd4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .re       (re),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .led_data (led_data),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("pass %s: 0x%08h", tag, got);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        cyc();
        we    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        re   = 1'b1;
        cyc();
        re   = 1'b0;
        check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
        check(tag, rdata, exp);
    endtask

    logic [3:0] chase_exp [4] = '{4'h2, 4'h4, 4'h8, 4'h1};

    initial begin
        int ticks;
        reset = 1'b1;
        addr  = 32'd0;
        wdata = 32'd0;
        we    = 1'b0;
        re    = 1'b0;
        cyc();
        cyc();
        check("rst_led", led_data, 32'd0);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b0;

        // Static pattern, default period of 4
        wr(32'h1000, 32'hA);
        check("t1_led_lag", led_data, 32'd0);
        cyc();
        check("t1_led", led_data, 32'hA);
        cyc();
        cyc();
        check("t1_tick_before", {31'd0, tick}, 32'd0);
        cyc();
        check("t1_tick", {31'd0, tick}, 32'd1);
        cyc();
        check("t1_tick_after", {31'd0, tick}, 32'd0);
        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (tick) ticks++;
        end
        check("t1_tick_count", ticks, 32'd3);
        check("t1_led_static", led_data, 32'hA);
        rd("t1_period", 32'h1008, 32'd4);

        // Blink
        wr(32'h1008, 32'd4);
        wr(32'h1000, 32'h5);
        wr(32'h1004, 32'd1);
        cyc();
        check("t2_led_on", led_data, 32'h5);
        cyc();
        cyc();
        cyc();
        check("t2_tick1", {31'd0, tick}, 32'd1);
        check("t2_led_still_on", led_data, 32'h5);
        cyc();
        check("t2_led_off", led_data, 32'h0);
        check("t2_tick1_end", {31'd0, tick}, 32'd0);
        cyc();
        cyc();
        cyc();
        check("t2_tick2", {31'd0, tick}, 32'd1);
        cyc();
        check("t2_led_on_again", led_data, 32'h5);

        // Chase, with mid-sequence pattern rewrite
        wr(32'h1008, 32'd2);
        wr(32'h1000, 32'h1);
        wr(32'h1004, 32'd2);
        cyc();
        check("t3_chase0", led_data, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            cyc();
            check($sformatf("t3_chase%0d", i + 1), led_data, {28'd0, chase_exp[i]});
        end
        wr(32'h1000, 32'h3);
        cyc();
        check("t3_restart", led_data, 32'h3);
        cyc();
        cyc();
        check("t3_restart_rot", led_data, 32'h6);

        // PERIOD of 0 stores 1
        wr(32'h1008, 32'd0);
        rd("t4_period", 32'h1008, 32'd1);
        check("t4_tick0", {31'd0, tick}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("t4_tick%0d", i + 1), {31'd0, tick}, 32'd1);
            if (i == 0) check("t4_rvalid_pulse", {31'd0, rvalid}, 32'd0);
        end

        // Same-edge read/write, decode misses, status
        wr(32'h1004, 32'd0);
        wr(32'h1000, 32'h5);
        addr  = 32'h1000;
        wdata = 32'h9;
        we    = 1'b1;
        re    = 1'b1;
        cyc();
        we    = 1'b0;
        re    = 1'b0;
        check("t5_rw_rvalid", {31'd0, rvalid}, 32'd1);
        check("t5_rw_old", rdata, 32'h5);
        rd("t5_new", 32'h1000, 32'h9);
        wr(32'h1010, 32'hF);
        rd("t5_miss_wr", 32'h1000, 32'h9);
        addr = 32'h1010;
        re   = 1'b1;
        cyc();
        re   = 1'b0;
        check("t5_miss_rvalid", {31'd0, rvalid}, 32'd0);
        check("t5_miss_rdata", rdata, 32'h9);
        rd("t5_status_static", 32'h100C, 32'h29);
        wr(32'h1004, 32'd1);
        rd("t5_status_blink", 32'h100C, 32'h39);

        // Reset in the middle of chasing
        wr(32'h1008, 32'd3);
        wr(32'h1000, 32'h1);
        wr(32'h1004, 32'd2);
        cyc();
        cyc();
        reset = 1'b1;
        addr  = 32'h1008;
        re    = 1'b1;
        cyc();
        reset = 1'b0;
        re    = 1'b0;
        check("t6_led", led_data, 32'd0);
        check("t6_rvalid", {31'd0, rvalid}, 32'd0);
        check("t6_tick", {31'd0, tick}, 32'd0);
        check("t6_rdata", rdata, 32'd0);
        rd("t6_pattern", 32'h1000, 32'd0);
        rd("t6_mode", 32'h1004, 32'd0);
        rd("t6_period", 32'h1008, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
